// File: rtl/seq_logic_pkg.sv
// Shared definitions for the sequential logic unit: op encoding and FSM states.
package seq_logic_pkg;

  // Operation select encoding
  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_XNOR  = 3'd3;
  localparam logic [2:0] OP_NAND  = 3'd4;
  localparam logic [2:0] OP_NOR   = 3'd5;
  localparam logic [2:0] OP_NOTA  = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_logic_unit_logic_slice.sv
// Combinational SLICE-bit logic lane.
// Ports:
//   a_i, b_i : SLICE-bit operand slices
//   op_i     : operation select (seq_logic_pkg OP_* encoding)
//   y_o      : SLICE-bit result slice
//   eq_o     : 1 when a_i == b_i on this slice
module logic_slice
  import seq_logic_pkg::*;
#(
  parameter int unsigned SLICE = 2
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic [SLICE-1:0] y_o,
  output logic             eq_o
);

  // Bitwise operation select
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:   y_o = a_i & b_i;
      OP_OR:    y_o = a_i | b_i;
      OP_XOR:   y_o = a_i ^ b_i;
      OP_XNOR:  y_o = a_i ~^ b_i;
      OP_NAND:  y_o = ~(a_i & b_i);
      OP_NOR:   y_o = ~(a_i | b_i);
      OP_NOTA:  y_o = ~a_i;
      OP_PASSA: y_o = a_i;
      default:  y_o = '0;
    endcase
  end

  // Slice equality is the AND of all XNOR bits, independent of op
  assign eq_o = &(a_i ~^ b_i);

endmodule

// File: rtl/seq_logic_unit.sv
// Sequential bitwise logic unit: processes WIDTH-bit operands SLICE bits per
// cycle (LSB slice first) under valid/ready handshakes, with eq/parity/zero flags.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   A, B, op            : operands and operation, latched at acceptance
//   out_valid/out_ready : result handshake; results held while out_ready=0
//   Output              : WIDTH-bit result
//   eq, parity, zero    : A==B, XOR-reduction of Output, Output==0
module seq_logic_unit
  import seq_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Output,
  output logic             eq,
  output logic             parity,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / ((SLICE == 0) ? 1 : SLICE);
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Reject slice widths that do not tile the operand exactly
  if (SLICE == 0 || WIDTH == 0) begin : g_bad_param
    $error("seq_logic_unit: WIDTH and SLICE must be >= 1");
  end else if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("seq_logic_unit: SLICE must divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             eq_q, eq_d;
  logic             par_q, par_d;
  logic             zero_q, zero_d;
  logic             ov_q, ov_d;

  logic [SLICE-1:0] a_sl, b_sl, y_sl;
  logic             sl_eq;

  // Select the operand slice addressed by the counter
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        a_sl = a_q[i*SLICE +: SLICE];
        b_sl = b_q[i*SLICE +: SLICE];
      end
    end
  end

  logic_slice #(.SLICE(SLICE)) u_slice (
    .a_i  (a_sl),
    .b_i  (b_sl),
    .op_i (op_q),
    .y_o  (y_sl),
    .eq_o (sl_eq)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    out_d   = out_q;
    eq_d    = eq_q;
    par_d   = par_q;
    zero_d  = zero_q;
    ov_d    = ov_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          op_d    = op;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        for (int unsigned i = 0; i < NSLICE; i++) begin
          if (cnt_q == CW'(i)) begin
            out_d[i*SLICE +: SLICE] = y_sl;
          end
        end
        // First slice seeds the accumulator so stale eq never leaks in
        eq_d = (cnt_q == '0) ? sl_eq : (eq_q & sl_eq);
        if (cnt_q == CW'(NSLICE - 1)) begin
          // Flags are taken from the completed result on the final slice
          par_d   = ^out_d;
          zero_d  = (out_d == '0);
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      out_q   <= '0;
      eq_q    <= 1'b0;
      par_q   <= 1'b0;
      zero_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      out_q   <= out_d;
      eq_q    <= eq_d;
      par_q   <= par_d;
      zero_q  <= zero_d;
      ov_q    <= ov_d;
    end
  end

  // in_ready is gated by rst so it reads 0 throughout reset
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = ov_q;
  assign Output    = out_q;
  assign eq        = eq_q;
  assign parity    = par_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_logic_unit.sv
// Directed self-checking bench for seq_logic_unit (WIDTH=8, SLICE=2).
module tb_seq_logic_unit;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SLICE  = 2;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Output;
  logic             eq;
  logic             parity;
  logic             zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_logic_unit #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Output    (Output),
    .eq        (eq),
    .parity    (parity),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one transaction and consume the acceptance edge
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    A = a;
    B = b;
    op = o;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("accept_in_ready", in_ready, 0);
  endtask

  // Wait (bounded) for out_valid, then check latency and result
  task automatic wait_result(input string tag, input logic [7:0] exp_out,
                             input logic exp_eq, input logic exp_par, input logic exp_zero);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, NSLICE);
    check({tag, "_out"},     Output, exp_out);
    check({tag, "_eq"},      eq, exp_eq);
    check({tag, "_parity"},  parity, exp_par);
    check({tag, "_zero"},    zero, exp_zero);
  endtask

  // Result is drained (out_ready already high) and unit returns to IDLE
  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    check({tag, "_ov_drop"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  logic [7:0] sweep_exp [8];
  logic       seen_valid;

  initial begin
    sweep_exp[0] = 8'h42; sweep_exp[1] = 8'hDB; sweep_exp[2] = 8'h99; sweep_exp[3] = 8'h66;
    sweep_exp[4] = 8'hBD; sweep_exp[5] = 8'h24; sweep_exp[6] = 8'h3C; sweep_exp[7] = 8'hC3;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; op = '0;

    // 1. reset
    step();
    step();
    check("rst_in_ready_low", in_ready, 0);
    rst = 1'b0;
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_output", Output, 8'h00);
    check("rst_eq", eq, 0);
    check("rst_parity", parity, 0);
    check("rst_zero", zero, 0);
    check("rst_in_ready", in_ready, 1);

    // 2. XNOR of equal operands
    accept(8'hA5, 8'hA5, 3'd3);
    wait_result("xnor_eq", 8'hFF, 1'b1, 1'b0, 1'b0);
    drain("xnor_eq");

    // 3. XOR cases
    accept(8'h0F, 8'h01, 3'd2);
    wait_result("xor_0e", 8'h0E, 1'b0, 1'b1, 1'b0);
    drain("xor_0e");
    accept(8'h3C, 8'h3C, 3'd2);
    wait_result("xor_zero", 8'h00, 1'b1, 1'b0, 1'b1);
    drain("xor_zero");

    // 4. op sweep
    for (int i = 0; i < 8; i++) begin
      accept(8'hC3, 8'h5A, 3'(i));
      wait_result($sformatf("sweep_op%0d", i), sweep_exp[i], 1'b0, 1'b0, 1'b0);
      drain($sformatf("sweep_op%0d", i));
    end

    // 5. backpressure in DONE with competing input offer
    out_ready = 1'b0;
    accept(8'h12, 8'h34, 3'd2);
    wait_result("bp", 8'h26, 1'b0, 1'b1, 1'b0);
    A = 8'hFF; B = 8'h00; op = 3'd0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_ov", out_valid, 1);
      check("bp_hold_out", Output, 8'h26);
      check("bp_hold_eq", eq, 0);
      check("bp_hold_parity", parity, 1);
      check("bp_hold_zero", zero, 0);
      check("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_ov", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_new_accept", in_ready, 0);
    wait_result("bp_new", 8'h00, 1'b0, 1'b0, 1'b1);
    drain("bp_new");

    // 6. reset during the second BUSY cycle
    accept(8'h55, 8'hAA, 3'd1);
    step();
    rst = 1'b1;
    step();
    check("abort_output", Output, 8'h00);
    check("abort_ov", out_valid, 0);
    check("abort_eq", eq, 0);
    check("abort_in_ready_rst", in_ready, 0);
    rst = 1'b0;
    seen_valid = 1'b0;
    step();
    check("abort_in_ready", in_ready, 1);
    for (int c = 0; c < 10; c++) begin
      if (out_valid) seen_valid = 1'b1;
      step();
    end
    check("abort_no_result", seen_valid, 0);

    // Recovery after abort
    accept(8'hFF, 8'h0F, 3'd0);
    wait_result("recover", 8'h0F, 1'b0, 1'b0, 1'b0);
    drain("recover");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
